// File: rtl/rv_pkg.sv
// Shared RISC-V decode constants: major opcodes, one-hot format indices and
// the opcode-to-format map, which depends on XLEN.
package rv_pkg;

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM32 = 5'b00110;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_OP32     = 5'b01110;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    localparam int FMT_R = 0;
    localparam int FMT_I = 1;
    localparam int FMT_S = 2;
    localparam int FMT_B = 3;
    localparam int FMT_U = 4;
    localparam int FMT_J = 5;
    localparam int FMT_W = 6;

    // One-hot format for a 7-bit opcode; all-zero means unsupported at this XLEN.
    function automatic logic [FMT_W-1:0] decode_format(input logic [6:0] opcode, input int xlen);
        logic [FMT_W-1:0] fmt;
        fmt = '0;
        if (opcode[1:0] == 2'b11) begin
            case (opcode[6:2])
                OPC_LUI, OPC_AUIPC:                fmt[FMT_U] = 1'b1;
                OPC_JAL:                           fmt[FMT_J] = 1'b1;
                OPC_BRANCH:                        fmt[FMT_B] = 1'b1;
                OPC_STORE:                         fmt[FMT_S] = 1'b1;
                OPC_JALR, OPC_LOAD, OPC_OP_IMM,
                OPC_MISC_MEM, OPC_SYSTEM:          fmt[FMT_I] = 1'b1;
                OPC_OP:                            fmt[FMT_R] = 1'b1;
                OPC_OP_IMM32:                      fmt[FMT_I] = (xlen == 64);
                OPC_OP32:                          fmt[FMT_R] = (xlen == 64);
                default:                           fmt = '0;
            endcase
        end
        return fmt;
    endfunction

endpackage

// File: rtl/imm_gen_x.sv
// Combinational instruction-format decode and XLEN-wide sign-extended
// immediate construction.
module imm_gen_x
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]      i_inst,
    output logic [FMT_W-1:0] o_format,
    output logic [XLEN-1:0]  o_immediate,
    output logic             o_illegal
);

    logic s;
    assign s = i_inst[31];

    always_comb begin
        o_format    = decode_format(i_inst[6:0], XLEN);
        o_illegal   = (o_format == '0);
        o_immediate = '0;
        if (o_format[FMT_I]) begin
            o_immediate = {{(XLEN-11){s}}, i_inst[30:20]};
        end else if (o_format[FMT_S]) begin
            o_immediate = {{(XLEN-11){s}}, i_inst[30:25], i_inst[11:7]};
        end else if (o_format[FMT_B]) begin
            o_immediate = {{(XLEN-12){s}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
        end else if (o_format[FMT_U]) begin
            o_immediate = {{(XLEN-31){s}}, i_inst[30:12], 12'b0};
        end else if (o_format[FMT_J]) begin
            o_immediate = {{(XLEN-20){s}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
        end
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode pipeline stage with valid/ready handshake and
// an optional second (skid) entry that absorbs one cycle of back-pressure.
//
// state    | meaning
// ST_EMPTY | no beat held, o_valid=0
// ST_ONE   | decoded beat in output register
// ST_TWO   | output register and skid entry both full, o_ready=0 (SKID=1 only)
module imm_decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter bit SKID  = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_inst,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_inst,
    output logic [TAG_W-1:0] o_tag,
    output logic [FMT_W-1:0] o_format,
    output logic [XLEN-1:0]  o_immediate,
    output logic             o_illegal
);

    typedef struct packed {
        logic [31:0]      inst;
        logic [TAG_W-1:0] tag;
        logic [FMT_W-1:0] fmt;
        logic [XLEN-1:0]  imm;
        logic             illegal;
    } beat_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

    state_t           state_q;
    beat_t            out_q;
    beat_t            skid_q;
    beat_t            beat_d;
    logic             valid_q;
    logic             ready_q;
    logic [FMT_W-1:0] gen_fmt;
    logic [XLEN-1:0]  gen_imm;
    logic             gen_ill;
    logic             in_fire;
    logic             out_fire;

    imm_gen_x #(.XLEN(XLEN)) u_imm_gen (
        .i_inst      (i_inst),
        .o_format    (gen_fmt),
        .o_immediate (gen_imm),
        .o_illegal   (gen_ill)
    );

    assign beat_d = {i_inst, i_tag, gen_fmt, gen_imm, gen_ill};

    // Without a skid entry, ONE can only accept when it also drains, so TWO is unreachable.
    assign o_ready  = SKID ? ready_q : (!valid_q || i_ready);
    assign in_fire  = i_valid && o_ready && !i_flush;
    assign out_fire = valid_q && i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            out_q   <= '0;
            skid_q  <= '0;
        end else if (i_flush) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        out_q   <= beat_d;
                        state_q <= ST_ONE;
                        valid_q <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        out_q <= beat_d;
                    end else if (in_fire) begin
                        skid_q  <= beat_d;
                        state_q <= ST_TWO;
                        ready_q <= 1'b0;
                    end else if (out_fire) begin
                        state_q <= ST_EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        out_q   <= skid_q;
                        state_q <= ST_ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_valid     = valid_q;
    assign o_inst      = out_q.inst;
    assign o_tag       = out_q.tag;
    assign o_format    = out_q.fmt;
    assign o_immediate = out_q.imm;
    assign o_illegal   = out_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: four instances (XLEN 32/64 x SKID 0/1) share
// one input stream; each has its own queue-based reference model.
module tb_imm_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        valid;
    logic        ready;
    logic [31:0] inst;
    logic [31:0] tag;

    logic        vld  [4];
    logic        rdy  [4];
    logic        oill [4];
    logic [31:0] oinst[4];
    logic [31:0] otag [4];
    logic [5:0]  ofmt [4];
    logic [63:0] oimm [4];

    int n_cmp = 0;
    int n_bad = 0;

    // Expected contents of each instance, oldest first: {tag, inst}.
    bit [63:0] mq [4][$];
    bit        acc[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int XL = (g >= 2) ? 64 : 32;
        localparam bit SK = (g % 2) == 1;
        logic          v, r, il;
        logic [31:0]   oi, ot;
        logic [5:0]    of;
        logic [XL-1:0] im;

        imm_decode_stage #(.XLEN(XL), .TAG_W(32), .SKID(SK)) u_dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_flush     (flush),
            .i_valid     (valid),
            .o_ready     (r),
            .i_inst      (inst),
            .i_tag       (tag),
            .o_valid     (v),
            .i_ready     (ready),
            .o_inst      (oi),
            .o_tag       (ot),
            .o_format    (of),
            .o_immediate (im),
            .o_illegal   (il)
        );

        assign vld[g]   = v;
        assign rdy[g]   = r;
        assign oill[g]  = il;
        assign oinst[g] = oi;
        assign otag[g]  = ot;
        assign ofmt[g]  = of;
        assign oimm[g]  = 64'(im);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference decode from the architectural immediate definitions, using signed arithmetic.
    function automatic void ref_decode(input logic [31:0] in, input bit x64,
                                       output logic [5:0] fmt, output logic [63:0] imm,
                                       output logic ill);
        longint sx, a20, a25, a31;
        sx  = longint'(signed'(in));
        a20 = sx >>> 20;
        a25 = sx >>> 25;
        a31 = sx >>> 31;
        fmt = 6'b0;
        if (in[1:0] == 2'b11) begin
            case (in[6:2])
                5'b01101, 5'b00101:                         fmt = 6'b010000;
                5'b11011:                                   fmt = 6'b100000;
                5'b11000:                                   fmt = 6'b001000;
                5'b01000:                                   fmt = 6'b000100;
                5'b11001, 5'b00000, 5'b00100, 5'b00011,
                5'b11100:                                   fmt = 6'b000010;
                5'b01100:                                   fmt = 6'b000001;
                5'b00110:                                   fmt = x64 ? 6'b000010 : 6'b0;
                5'b01110:                                   fmt = x64 ? 6'b000001 : 6'b0;
                default:                                    fmt = 6'b0;
            endcase
        end
        case (fmt)
            6'b000010: imm = a20;
            6'b000100: imm = (a25 << 5) | 64'(in[11:7]);
            6'b001000: imm = (a31 << 12) | (64'(in[7]) << 11) | (64'(in[30:25]) << 5) | (64'(in[11:8]) << 1);
            6'b010000: imm = sx & ~64'hFFF;
            6'b100000: imm = (a31 << 20) | (64'(in[19:12]) << 12) | (64'(in[20]) << 11) | (64'(in[30:21]) << 1);
            default:   imm = 64'h0;
        endcase
        if (!x64) imm = imm & 64'hFFFF_FFFF;
        ill = (fmt == 6'b0);
    endfunction

    task automatic check_outputs();
        logic [31:0] et, ei;
        logic [5:0]  ef;
        logic [63:0] eimm;
        logic        eill;
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("dut%0d o_valid", g), 64'(vld[g]), 64'(mq[g].size() > 0));
            if (mq[g].size() > 0) begin
                {et, ei} = mq[g][0];
                ref_decode(ei, g >= 2, ef, eimm, eill);
                chk($sformatf("dut%0d o_inst", g),      64'(oinst[g]), 64'(ei));
                chk($sformatf("dut%0d o_tag", g),       64'(otag[g]),  64'(et));
                chk($sformatf("dut%0d o_format", g),    64'(ofmt[g]),  64'(ef));
                chk($sformatf("dut%0d o_immediate", g), oimm[g],       eimm);
                chk($sformatf("dut%0d o_illegal", g),   64'(oill[g]),  64'(eill));
            end
        end
    endtask

    task automatic step_model();
        bit er;
        for (int g = 0; g < 4; g++) begin
            er = (g % 2 == 1) ? (mq[g].size() < 2) : (mq[g].size() == 0 || ready);
            chk($sformatf("dut%0d o_ready", g), 64'(rdy[g]), 64'(er));
            acc[g] = 1'b0;
            if (flush) begin
                mq[g].delete();
            end else begin
                if (mq[g].size() > 0 && ready) void'(mq[g].pop_front());
                if (valid && er) begin
                    mq[g].push_back({tag, inst});
                    acc[g] = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle(input bit v, input logic [31:0] in, input logic [31:0] tg,
                         input bit rd, input bit fl);
        @(negedge clk);
        check_outputs();
        valid = v;
        inst  = in;
        tag   = tg;
        ready = rd;
        flush = fl;
        #1;
        step_model();
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [5:0]  f32;
        logic [63:0] i32;
        logic        l32;
        logic [5:0]  f64;
        logic [63:0] i64;
        logic        l64;
    } vec_t;

    vec_t        vt[10];
    logic [4:0]  ops[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        bit          v, rd, fl;

        vt[0] = '{32'hFFF00093, 6'b000010, 64'hFFFF_FFFF, 1'b0, 6'b000010, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vt[1] = '{32'hFE000EE3, 6'b001000, 64'hFFFF_FFFC, 1'b0, 6'b001000, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vt[2] = '{32'h800000B7, 6'b010000, 64'h8000_0000, 1'b0, 6'b010000, 64'hFFFF_FFFF_8000_0000, 1'b0};
        vt[3] = '{32'h0000007F, 6'b000000, 64'h0,         1'b1, 6'b000000, 64'h0,                  1'b1};
        vt[4] = '{32'h00000000, 6'b000000, 64'h0,         1'b1, 6'b000000, 64'h0,                  1'b1};
        vt[5] = '{32'h0000003B, 6'b000000, 64'h0,         1'b1, 6'b000001, 64'h0,                  1'b0};
        vt[6] = '{32'h00112423, 6'b000100, 64'h8,         1'b0, 6'b000100, 64'h8,                  1'b0};
        vt[7] = '{32'h008000EF, 6'b100000, 64'h8,         1'b0, 6'b100000, 64'h8,                  1'b0};
        vt[8] = '{32'hFFF0809B, 6'b000000, 64'h0,         1'b1, 6'b000010, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vt[9] = '{32'h002081B3, 6'b000001, 64'h0,         1'b0, 6'b000001, 64'h0,                  1'b0};

        ops = '{5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01000, 5'b01100,
                5'b01101, 5'b01110, 5'b11000, 5'b11001, 5'b11011, 5'b11100};

        rst_n = 1'b0; flush = 1'b0; valid = 1'b0; ready = 1'b0; inst = '0; tag = '0;
        repeat (2) @(negedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("dut%0d reset o_valid", g),     64'(vld[g]),  64'h0);
            chk($sformatf("dut%0d reset o_ready", g),     64'(rdy[g]),  64'h1);
            chk($sformatf("dut%0d reset o_immediate", g), oimm[g],      64'h0);
            chk($sformatf("dut%0d reset o_format", g),    64'(ofmt[g]), 64'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven decode vectors, one beat each with i_ready held high.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, vt[i].inst, 32'h100 + i, 1'b1, 1'b0);
            @(posedge clk);
            #1;
            for (int g = 0; g < 4; g++) begin
                chk($sformatf("vec%0d dut%0d valid", i, g), 64'(vld[g]), 64'h1);
                chk($sformatf("vec%0d dut%0d format", i, g), 64'(ofmt[g]),
                    64'((g >= 2) ? vt[i].f64 : vt[i].f32));
                chk($sformatf("vec%0d dut%0d imm", i, g), oimm[g],
                    (g >= 2) ? vt[i].i64 : vt[i].i32);
                chk($sformatf("vec%0d dut%0d illegal", i, g), 64'(oill[g]),
                    64'((g >= 2) ? vt[i].l64 : vt[i].l32));
            end
        end
        repeat (2) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Back-pressure: A, B into the skid instances, C held upstream.
        cycle(1'b1, 32'hFFF00093, 32'hAAAA, 1'b0, 1'b0);
        cycle(1'b1, 32'hFE000EE3, 32'hBBBB, 1'b0, 1'b0);
        cycle(1'b1, 32'h800000B7, 32'hCCCC, 1'b0, 1'b0);
        chk("skid dut1 o_ready after B", 64'(rdy[1]), 64'h0);
        chk("skid dut3 o_ready after B", 64'(rdy[3]), 64'h0);
        cycle(1'b1, 32'h800000B7, 32'hCCCC, 1'b0, 1'b0);
        cycle(1'b1, 32'h800000B7, 32'hCCCC, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("skid dut1 second tag", 64'(otag[1]), 64'hBBBB);
        chk("skid dut3 second tag", 64'(otag[3]), 64'hBBBB);
        begin
            int n;
            n = 0;
            do begin
                cycle(1'b1, 32'h800000B7, 32'hCCCC, 1'b1, 1'b0);
                n++;
            end while (!acc[1] && n < 8);
            chk("skid dut1 C accepted", 64'(acc[1]), 64'h1);
        end
        @(posedge clk);
        #1;
        chk("skid dut1 third tag", 64'(otag[1]), 64'hCCCC);
        chk("skid dut1 third valid", 64'(vld[1]), 64'h1);
        repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush while the skid instances hold two beats and a new beat is offered.
        cycle(1'b1, 32'h00112423, 32'hD001, 1'b0, 1'b0);
        cycle(1'b1, 32'h008000EF, 32'hD002, 1'b0, 1'b0);
        cycle(1'b1, 32'h002081B3, 32'hD003, 1'b0, 1'b1);
        chk("flush dut1 in TWO", 64'(rdy[1]), 64'h0);
        @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("flush dut%0d o_valid", g), 64'(vld[g]), 64'h0);
            chk($sformatf("flush dut%0d o_ready", g), 64'(rdy[g]), 64'h1);
        end
        repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Randomised traffic with back-pressure and occasional flush.
        for (int k = 0; k < 3000; k++) begin
            r = $urandom();
            if ($urandom_range(0, 9) != 0) r[6:0] = {ops[$urandom_range(0, 12)], 2'b11};
            v  = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 40) == 0);
            cycle(v, r, $urandom(), rd, fl);
        end

        // Asynchronous reset mid-stream.
        cycle(1'b1, 32'hFFF00093, 32'hE001, 1'b0, 1'b0);
        cycle(1'b1, 32'h800000B7, 32'hE002, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        valid = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("async rst dut%0d o_valid", g),     64'(vld[g]), 64'h0);
            chk($sformatf("async rst dut%0d o_ready", g),     64'(rdy[g]), 64'h1);
            chk($sformatf("async rst dut%0d o_immediate", g), oimm[g],     64'h0);
            mq[g].delete();
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
